// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_loader_pkg
// Description : Shared types and constants for the instruction memory loader.
//               INSTR_LOADER_CHECKSUM_EN adds the CSUM state.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_loader_pkg;

    localparam int LEN_BYTES = 4;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : loader_byte_packer
// Description : Packs a byte stream into little-endian 32-bit words; the 4th
//               byte is passed straight through so the word is ready that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module loader_byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] fill;

    assign word_valid = byte_en && (cnt == 2'(LEN_BYTES - 1));
    assign word       = {byte_in, fill};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 2'd0;
            fill <= 24'd0;
        end else if (clear) begin
            cnt  <= 2'd0;
            fill <= 24'd0;
        end else if (byte_en) begin
            case (cnt)
                2'd0:    fill[7:0]   <= byte_in;
                2'd1:    fill[15:8]  <= byte_in;
                2'd2:    fill[23:16] <= byte_in;
                default: fill        <= fill;
            endcase
            cnt <= cnt + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_loader
// Description : Loads instruction memory from a length-prefixed byte stream
//               and holds the core in reset until the load completes.
//               Define INSTR_LOADER_CHECKSUM_EN for a trailing XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int MEM_SIZE_WORDS = 1024,
    parameter int WCNT_W         = $clog2(MEM_SIZE_WORDS) + 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    input  logic        start_i,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_o,
    output logic        done_o,
    output logic [1:0]  err_code_o
);

    loader_state_e      state, state_nxt;
    logic               finishing, fin_set;
    logic [31:0]        len;
    logic [WCNT_W-1:0]  widx;
    logic               accept, restart, go_data, len_over, len_zero, last_word;
    logic               pk_en, pk_clear, pk_valid;
    logic [31:0]        pk_word;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    // The finishing flag delays DONE by one edge so the final write lands first.
    always_comb begin
        in_ready_o = 1'b0;
        case (state)
            ST_LEN, ST_DATA: in_ready_o = !finishing;
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CSUM:         in_ready_o = !finishing;
`endif
            default:         in_ready_o = 1'b0;
        endcase
    end

    assign accept     = in_valid_i && in_ready_o;
    assign restart    = ((state == ST_DONE) || (state == ST_ERR)) && start_i;
    assign len_over   = pk_word > 32'(MEM_SIZE_WORDS);
    assign len_zero   = (pk_word == 32'd0);
    assign go_data    = (state == ST_LEN) && pk_valid && !len_over && !len_zero;
    assign last_word  = (state == ST_DATA) && pk_valid &&
                        ({{(32-WCNT_W){1'b0}}, widx} == (len - 32'd1));
    assign pk_en      = accept && ((state == ST_LEN) || (state == ST_DATA));
    assign pk_clear   = go_data || restart;
    assign done_o     = (state == ST_DONE);
    assign core_rst_o = (state != ST_DONE);

    loader_byte_packer u_packer (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .clear      (pk_clear),
        .byte_en    (pk_en),
        .byte_in    (in_data_i),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fin_set   = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_LEN;
            ST_LEN: begin
                if (finishing) begin
                    state_nxt = ST_DONE;
                end else if (pk_valid) begin
                    if (len_over) begin
                        state_nxt = ST_ERR;
                    end else if (len_zero) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_nxt = ST_CSUM;
`else
                        fin_set   = 1'b1;
`endif
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (finishing) begin
                    state_nxt = ST_DONE;
                end else if (last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    state_nxt = ST_CSUM;
`else
                    fin_set   = 1'b1;
`endif
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (finishing) begin
                    state_nxt = ST_DONE;
                end else if (accept) begin
                    if (in_data_i == csum) fin_set   = 1'b1;
                    else                   state_nxt = ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: if (start_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            finishing   <= 1'b0;
            len         <= 32'd0;
            widx        <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
            err_code_o  <= ERR_NONE;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum        <= 8'd0;
`endif
        end else begin
            finishing <= fin_set;
            mem_we_o  <= 1'b0;
            if (restart) begin
                len        <= 32'd0;
                widx       <= '0;
                err_code_o <= ERR_NONE;
`ifdef INSTR_LOADER_CHECKSUM_EN
                csum       <= 8'd0;
`endif
            end
            if ((state == ST_LEN) && pk_valid) begin
                len <= pk_word;
                if (len_over) err_code_o <= ERR_LEN;
            end
            if ((state == ST_DATA) && pk_valid) begin
                mem_we_o    <= 1'b1;
                mem_addr_o  <= {{(30-WCNT_W){1'b0}}, widx, 2'b00};
                mem_wdata_o <= pk_word;
                widx        <= widx + WCNT_W'(1);
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            if ((state == ST_DATA) && accept) csum <= csum ^ in_data_i;
            if ((state == ST_CSUM) && accept && !finishing && (in_data_i != csum))
                err_code_o <= ERR_CSUM;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_loader
// Description : Table-driven self-checking bench for instr_mem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        start;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        done;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;

    instr_mem_loader dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .start_i     (start),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .core_rst_o  (core_rst),
        .done_o      (done),
        .err_code_o  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]   nbytes;
        logic [159:0] stream;
        logic [2:0]   nw;
        logic [127:0] words;
        logic [1:0]   err;
        logic         fin;
        logic         gaps;
    } vec_t;

`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam int NV = 6;
`else
    localparam int NV = 5;
`endif

    vec_t vecs[NV];

    // Write log filled by a single monitor process.
    logic [31:0] wr_addr[0:63];
    logic [31:0] wr_data[0:63];
    int          wn = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            if (wn < 64) begin
                wr_addr[wn] = mem_addr;
                wr_data[wn] = mem_wdata;
            end
            wn = wn + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 100 && !acc; t++) begin
            acc = in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL send_timeout actual=not_accepted required=accepted byte=%h", b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int base, input int nw,
                                input logic [127:0] words);
        chk({tag, "_wcount"}, 32'(wn - base), 32'(nw));
        for (int i = 0; i < nw && i < 4; i++) begin
            chk({tag, "_addr"}, wr_addr[base + i], 32'(i * 4));
            chk({tag, "_data"}, wr_data[base + i], words[i*32 +: 32]);
        end
    endtask

    initial begin
        int base;
        vec_t v;

        vecs[0] = '{nbytes: 5'd12, stream: 160'({32'h00100093, 32'h00500013, 32'd2}),
                    nw: 3'd2, words: 128'({32'h00100093, 32'h00500013}),
                    err: 2'b00, fin: 1'b1, gaps: 1'b0};
`ifdef INSTR_LOADER_CHECKSUM_EN
        vecs[1] = '{nbytes: 5'd5, stream: 160'd0, nw: 3'd0, words: 128'd0,
                    err: 2'b00, fin: 1'b1, gaps: 1'b0};
`else
        vecs[1] = '{nbytes: 5'd4, stream: 160'd0, nw: 3'd0, words: 128'd0,
                    err: 2'b00, fin: 1'b1, gaps: 1'b0};
`endif
        vecs[2] = '{nbytes: 5'd16,
                    stream: 160'({32'h00200113, 32'h00100093, 32'h00000013, 32'd3}),
                    nw: 3'd3, words: 128'({32'h00200113, 32'h00100093, 32'h00000013}),
                    err: 2'b00, fin: 1'b1, gaps: 1'b1};
        vecs[3] = '{nbytes: 5'd4, stream: 160'(32'h00000401), nw: 3'd0, words: 128'd0,
                    err: 2'b01, fin: 1'b0, gaps: 1'b0};
`ifdef INSTR_LOADER_CHECKSUM_EN
        vecs[4] = '{nbytes: 5'd9, stream: 160'({8'h44, 32'h44332211, 32'd1}),
                    nw: 3'd1, words: 128'(32'h44332211), err: 2'b00, fin: 1'b1, gaps: 1'b0};
        vecs[5] = '{nbytes: 5'd9, stream: 160'({8'h45, 32'h44332211, 32'd1}),
                    nw: 3'd1, words: 128'(32'h44332211), err: 2'b10, fin: 1'b0, gaps: 1'b0};
`else
        vecs[4] = '{nbytes: 5'd8, stream: 160'({32'h44332211, 32'd1}),
                    nw: 3'd1, words: 128'(32'h44332211), err: 2'b00, fin: 1'b1, gaps: 1'b0};
`endif

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        start    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready",    32'(in_ready),  32'd0);
        chk("rst_we",       32'(mem_we),    32'd0);
        chk("rst_addr",     mem_addr,       32'd0);
        chk("rst_wdata",    mem_wdata,      32'd0);
        chk("rst_core_rst", 32'(core_rst),  32'd1);
        chk("rst_done",     32'(done),      32'd0);
        chk("rst_err",      32'(err_code),  32'd0);
        rst_n = 1'b1;
        #1 chk("idle_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("len_ready", 32'(in_ready), 32'd1);

        for (int vi = 0; vi < NV; vi++) begin
            v = vecs[vi];
            if (vi > 0) begin
                pulse_start();
                chk("restart_done", 32'(done),     32'd0);
                chk("restart_err",  32'(err_code), 32'd0);
                chk("restart_core", 32'(core_rst), 32'd1);
            end
            base = wn;
            for (int i = 0; i < int'(v.nbytes); i++) begin
                if (v.gaps) begin
                    // start_i must be ignored mid-load
                    start = 1'b1;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        @(negedge clk);
                    end
                    start = 1'b0;
                end
                send_byte(v.stream[i*8 +: 8]);
            end
            if (v.fin) chk("done_early", 32'(done), 32'd0);
            chk("err_at_edge", 32'(err_code), 32'(v.err));
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("vec_done",     32'(done),     32'(v.fin));
            chk("vec_core_rst", 32'(core_rst), 32'(!v.fin));
            chk("vec_err",      32'(err_code), 32'(v.err));
            chk("vec_ready",    32'(in_ready), 32'd0);
            check_writes("vec", base, int'(v.nw), v.words);

            if (vi == 0) begin
                in_valid = 1'b1;
                in_data  = 8'hAA;
                repeat (4) begin
                    @(posedge clk);
                    @(negedge clk);
                    chk("extra_ready", 32'(in_ready), 32'd0);
                end
                in_valid = 1'b0;
                chk("extra_writes", 32'(wn - base), 32'd2);
            end
        end

        // Asynchronous reset in the middle of a write pulse, then a clean reload.
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h04 : 8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        chk("pulse_live", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_we",       32'(mem_we),   32'd0);
        chk("arst_addr",     mem_addr,      32'd0);
        chk("arst_wdata",    mem_wdata,     32'd0);
        chk("arst_ready",    32'(in_ready), 32'd0);
        chk("arst_core_rst", 32'(core_rst), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        base = wn;
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h04 : 8'h00);
        begin
            logic [127:0] w4;
            w4 = {32'h00300193, 32'h00200113, 32'h00100093, 32'h00000013};
            for (int i = 0; i < 16; i++) send_byte(w4[i*8 +: 8]);
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("reload_done", 32'(done), 32'd1);
            check_writes("reload", base, 4, w4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
